// File: rtl/reg_write_sched.sv
// reg_write_sched: buffered register-file write scheduler.
// Write requests are queued in a small FIFO. Each one is decoded into per-byte-lane
// write enables. At most one write issues per cycle, and issue stalls while HOLD is high.
// Requests that cannot be decoded are consumed normally and reported through ERR/ERR_CNT.
module reg_write_sched #(
  parameter int NUM_REGS      = 8,
  parameter int NUM_BYTE_REGS = 4,
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 2,
  parameter int IDX_W         = $clog2(NUM_REGS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [1:0]            REQ_SIZE,
  input  logic [IDX_W-1:0]      REQ_IDX,
  input  logic [DATA_W-1:0]     REQ_DATA,
  input  logic                  HOLD,
  input  logic                  ERR_CLR,
  output logic [2*NUM_REGS-1:0] WE,
  output logic [DATA_W-1:0]     WDATA,
  output logic                  ERR,
  output logic [7:0]            ERR_CNT
);

  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] SZ_LO   = 2'b00;
  localparam logic [1:0] SZ_HI   = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // FIFO storage (not reset; validity is tracked by r_count)
  logic [1:0]        r_size [DEPTH];
  logic [IDX_W-1:0]  r_idx  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_head_size;
  logic [IDX_W-1:0]      w_head_idx;
  logic [DATA_W-1:0]     w_head_data;
  logic                  w_illegal;
  logic [2*NUM_REGS-1:0] w_we;
  logic [DATA_W-1:0]     w_wdata;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the registered count. A full FIFO refuses input even
  // when an entry pops on the same edge.
  assign REQ_READY = !RST && (r_count < CNT_W'(DEPTH));
  assign w_push    = REQ_VALID && REQ_READY;
  assign w_pop     = !RST && !HOLD && (r_count != '0);

  assign w_head_size = r_size[r_rd_ptr];
  assign w_head_idx  = r_idx[r_rd_ptr];
  assign w_head_data = r_data[r_rd_ptr];

  // Decode the FIFO head into lane enables, aligned data and a legality flag
  always_comb begin
    w_we      = '0;
    w_illegal = (w_head_size == SZ_RSVD) ||
                (int'(w_head_idx) >= NUM_REGS) ||
                ((w_head_size != SZ_WORD) && (int'(w_head_idx) >= NUM_BYTE_REGS));
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_head_idx == IDX_W'(i)) begin
        w_we[2*i]   = (w_head_size != SZ_HI);
        w_we[2*i+1] = (w_head_size != SZ_LO);
      end
    end
    if (w_illegal) begin
      w_we = '0;
    end
    w_wdata = (w_head_size == SZ_WORD) ? w_head_data
                                       : {2{w_head_data[HALF-1:0]}};
  end

  // Capture accepted requests into the FIFO storage
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_size[r_wr_ptr] <= REQ_SIZE;
      r_idx[r_wr_ptr]  <= REQ_IDX;
      r_data[r_wr_ptr] <= REQ_DATA;
    end
  end

  // FIFO bookkeeping, one-cycle write issue and the error flag/counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      WE       <= '0;
      WDATA    <= '0;
      ERR      <= 1'b0;
      ERR_CNT  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end

      WE <= '0;
      if (w_pop && !w_illegal) begin
        WE    <= w_we;
        WDATA <= w_wdata;
      end

      // An illegal pop outranks a clear on the same edge, so the new error is kept.
      if (w_pop && w_illegal) begin
        ERR <= 1'b1;
        if (ERR_CLR) begin
          ERR_CNT <= 8'd1;
        end else if (ERR_CNT != 8'hFF) begin
          ERR_CNT <= ERR_CNT + 8'd1;
        end
      end else if (ERR_CLR) begin
        ERR     <= 1'b0;
        ERR_CNT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_sched.sv
// Testbench for reg_write_sched: directed scenarios followed by random traffic.
// A transaction-level queue model supplies every expected value.
module tb_reg_write_sched;

  localparam int NR  = 8;
  localparam int NB  = 4;
  localparam int DW  = 16;
  localparam int DEP = 2;
  localparam int IW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_size = '0;
  logic [IW-1:0]   req_idx = '0;
  logic [DW-1:0]   req_data = '0;
  logic            hold = 1'b0;
  logic            err_clr = 1'b0;
  logic [2*NR-1:0] we;
  logic [DW-1:0]   wdata;
  logic            err;
  logic [7:0]      err_cnt;

  reg_write_sched #(
    .NUM_REGS(NR),
    .NUM_BYTE_REGS(NB),
    .DATA_W(DW),
    .DEPTH(DEP)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_SIZE(req_size),
    .REQ_IDX(req_idx),
    .REQ_DATA(req_data),
    .HOLD(hold),
    .ERR_CLR(err_clr),
    .WE(we),
    .WDATA(wdata),
    .ERR(err),
    .ERR_CNT(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  size;
    int unsigned idx;
    logic [DW-1:0] data;
  } req_t;

  req_t            q[$];
  logic [2*NR-1:0] m_we = '0;
  logic [DW-1:0]   m_wdata = '0;
  logic            m_err = 1'b0;
  logic [7:0]      m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input req_t r);
    return !(r.size == 2'b11 || r.idx >= NR || (r.size != 2'b10 && r.idx >= NB));
  endfunction

  function automatic logic [2*NR-1:0] exp_we(input req_t r);
    logic [2*NR-1:0] v;
    v = '0;
    if (legal(r)) begin
      v[1:0] = (r.size == 2'b10) ? 2'b11 : (r.size == 2'b00) ? 2'b01 : 2'b10;
      v = v << (2 * r.idx);
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_wdata(input req_t r);
    logic [DW/2-1:0] b;
    b = r.data[DW/2-1:0];
    return (r.size == 2'b10) ? r.data : {b, b};
  endfunction

  // One clock: drive inputs, check ready, clock the edge, update the model, then check outputs.
  task automatic cycle(input bit v, input logic [1:0] sz, input int unsigned ix,
                       input logic [DW-1:0] d, input bit h, input bit c, input bit r,
                       output bit acc);
    req_t nr;
    req_t p;
    bit   m_ready;
    bit   ill_pop;
    req_valid = v; req_size = sz; req_idx = IW'(ix); req_data = d;
    hold = h; err_clr = c; rst = r;
    m_ready = !r && (q.size() < DEP);
    #1;
    chk("ready", {63'd0, req_ready}, {63'd0, m_ready});
    acc = v && m_ready;
    nr.size = sz; nr.idx = ix; nr.data = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_we = '0; m_wdata = '0; m_err = 1'b0; m_cnt = '0;
    end else begin
      ill_pop = 1'b0;
      m_we = '0;
      if (!h && q.size() > 0) begin
        p = q.pop_front();
        if (legal(p)) begin
          m_we    = exp_we(p);
          m_wdata = exp_wdata(p);
        end else begin
          ill_pop = 1'b1;
        end
      end
      if (ill_pop) begin
        m_err = 1'b1;
        m_cnt = c ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
      end else if (c) begin
        m_err = 1'b0;
        m_cnt = '0;
      end
      if (acc) q.push_back(nr);
    end
    #1;
    chk("we", 64'(we), 64'(m_we));
    chk("wdata", 64'(wdata), 64'(m_wdata));
    chk("err", {63'd0, err}, {63'd0, m_err});
    chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
  endtask

  task automatic idle(input int n, input bit h);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 0, '0, h, 1'b0, 1'b0, acc);
  endtask

  // Holds a request on the bus until it is accepted, or until the cycle budget runs out.
  task automatic send(input logic [1:0] sz, input int unsigned ix, input logic [DW-1:0] d,
                      input bit h);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, sz, ix, d, h, 1'b0, 1'b0, acc);
    checks++;
    if (!acc) begin
      errors++;
      $error("FAIL send_timeout: request size=%0d idx=%0d not accepted", sz, ix);
    end
  endtask

  initial begin
    bit acc;
    int pulses;

    // Reset and idle state
    cycle(1'b0, 2'b00, 0, '0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 2'b00, 0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);

    // Byte and word decode
    send(2'b01, 2, 16'h00A5, 1'b0);
    send(2'b10, 6, 16'h1234, 1'b0);
    chk("dec_byte_we", 64'(we), 64'h0020);
    chk("dec_byte_wdata", 64'(wdata), 64'hA5A5);
    idle(1, 1'b0);
    chk("dec_word_we", 64'(we), 64'h3000);
    chk("dec_word_wdata", 64'(wdata), 64'h1234);
    idle(2, 1'b0);

    // Backpressure under HOLD
    send(2'b10, 0, 16'h1111, 1'b1);
    send(2'b00, 1, 16'h2222, 1'b1);
    chk("bp_ready_full", {63'd0, req_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b10, 7, 16'h3333, 1'b1, 1'b0, 1'b0, acc);
      chk("bp_third_waits", {63'd0, acc}, 64'd0);
    end
    cycle(1'b1, 2'b10, 7, 16'h3333, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_no_passthru", {63'd0, acc}, 64'd0);
    chk("bp_pop1_we", 64'(we), 64'h0003);
    cycle(1'b1, 2'b10, 7, 16'h3333, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_third_acc", {63'd0, acc}, 64'd1);
    chk("bp_pop2_we", 64'(we), 64'h0004);
    idle(1, 1'b0);
    chk("bp_pop3_we", 64'(we), 64'hC000);
    idle(2, 1'b0);

    // Illegal requests, clear, saturation, clear coinciding with an illegal pop
    send(2'b00, 5, 16'h0055, 1'b0);
    send(2'b11, 0, 16'h0066, 1'b0);
    idle(2, 1'b0);
    chk("ill_err", {63'd0, err}, 64'd1);
    chk("ill_cnt", 64'(err_cnt), 64'd2);
    cycle(1'b0, 2'b00, 0, '0, 1'b0, 1'b1, 1'b0, acc);
    chk("clr_err", {63'd0, err}, 64'd0);
    chk("clr_cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 300; i++) send(2'b11, $urandom_range(0, 7), 16'($urandom), 1'b0);
    idle(3, 1'b0);
    chk("sat_cnt", 64'(err_cnt), 64'd255);
    send(2'b11, 0, 16'h0000, 1'b0);
    cycle(1'b0, 2'b00, 0, '0, 1'b0, 1'b1, 1'b0, acc);
    chk("clr_pop_err", {63'd0, err}, 64'd1);
    chk("clr_pop_cnt", 64'(err_cnt), 64'd1);
    idle(2, 1'b0);

    // Streaming ten word writes back to back
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      send(2'b10, i % 8, 16'(i * 16'h0101), 1'b0);
      if (we != '0) pulses++;
    end
    for (int i = 0; i < 2; i++) begin
      idle(1, 1'b0);
      if (we != '0) pulses++;
    end
    chk("stream_pulses", 64'(pulses), 64'd10);

    // Reset with entries pending
    send(2'b10, 3, 16'hBEEF, 1'b1);
    send(2'b00, 0, 16'h00CC, 1'b1);
    cycle(1'b0, 2'b00, 0, '0, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      chk("midrst_no_we", 64'(we), 64'd0);
    end
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 7),
            16'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 49) == 0), acc);
    end
    idle(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_sched.md
Name: reg_write_sched

Overview:
- Parametrised, buffered successor to the combinational register-file write decoder.
- Accepts write requests over a valid/ready handshake and queues them in a small FIFO.
- Decodes each request into per-byte-lane write enables for NUM_REGS word registers. The first NUM_BYTE_REGS registers are byte-addressable as low/high halves (AL/AH-style); the rest are word-only.
- Issues one write per cycle to the register file, stalls under HOLD, and flags illegal requests.

Parameters:
- NUM_REGS, 8, number of word registers (>=2).
- NUM_BYTE_REGS, 4, registers 0..NUM_BYTE_REGS-1 allow byte access (<=NUM_REGS).
- DATA_W, 16, register width; must be even, and the byte half is DATA_W/2.
- DEPTH, 2, request FIFO entries (>=1).
- IDX_W, clog2(NUM_REGS), register index width (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  FIFO can accept (count < DEPTH).
- REQ_SIZE  in  2  00 low byte, 01 high byte, 10 word, 11 reserved.
- REQ_IDX  in  IDX_W  target register.
- REQ_DATA  in  DATA_W  write data; byte writes use bits [DATA_W/2-1:0].
- HOLD  in  1  datapath stall; no issue while high.
- ERR_CLR  in  1  clears ERR and ERR_CNT.
- WE  out  2*NUM_REGS  byte-lane enables: bit 2i = low half of reg i, bit 2i+1 = high half.
- WDATA  out  DATA_W  aligned write data.
- ERR  out  1  sticky illegal-request flag.
- ERR_CNT  out  8  saturating illegal-request count.

Behaviour:
- Reset: already decided — one clock CLK; RST is synchronous and active-high. RST high at an edge flushes the FIFO (count=0) and sets WE=0, WDATA=0, ERR=0, ERR_CNT=0. REQ_READY is 0 while RST is high and 1 in the first cycle after. A request presented in the same cycle as RST is dropped. Reset mid-queue discards pending entries, and no WE is issued for them.
- Accept: a request is pushed at an edge where REQ_VALID && REQ_READY. REQ_READY depends only on the registered count, so there is no combinational path from REQ_VALID. When full, REQ_READY stays 0 even if a pop happens in the same cycle (no pass-through).
- Issue: at each edge where RST=0, HOLD=0 and count>0, the oldest entry is popped, and WE/WDATA are registered from its decode. Outputs are valid for exactly one cycle; otherwise WE=0 and WDATA holds its last value.
- Latency: a request accepted at edge E into an empty FIFO with HOLD low drives WE in the cycle after edge E+1. Sustained throughput is 1 write/cycle.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- Decode (legal cases):
  - Word: WE bits 2i and 2i+1 set; WDATA=REQ_DATA.
  - Low byte: bit 2i set.
  - High byte: bit 2i+1 set.
  - For both byte sizes, WDATA = {b,b} with b = REQ_DATA[DATA_W/2-1:0], so the byte appears in both lanes.
  - At most one register's lanes are ever set.
- Illegal cases:
  - REQ_SIZE=11.
  - Byte size with REQ_IDX >= NUM_BYTE_REGS.
  - REQ_IDX >= NUM_REGS.
- Illegal-request handling: the entry is accepted and popped normally, then WE=0 for that slot. ERR is set on the pop edge, and ERR_CNT increments, saturating at 255.
- ERR_CLR: clears ERR and ERR_CNT at the edge. If an illegal pop occurs on the same edge, the result is ERR=1, ERR_CNT=1.
- HOLD: while HOLD is high, nothing pops and the FIFO keeps accepting until full. When HOLD drops, issue resumes on the next edge in FIFO order.

Test Plan:
- Reset/idle: RST high 2 cycles, then low -> WE=0, WDATA=0, ERR=0, ERR_CNT=0, REQ_READY=1 in the first cycle after reset.
- Byte/word decode: push (SIZE=01, IDX=2, DATA=16'h00A5), then (SIZE=10, IDX=6, DATA=16'h1234) with HOLD=0 -> on consecutive cycles WE=16'h0020 with WDATA=16'hA5A5, then WE=16'h3000 with WDATA=16'h1234.
- Backpressure: HOLD=1, push 3 requests with DEPTH=2 -> REQ_READY=0 after the 2nd accept and the 3rd waits. After HOLD=0, the three issue in order on consecutive cycles, and REQ_READY returns to 1 the cycle after the first pop.
- Illegal: push (SIZE=00, IDX=5), then (SIZE=11, IDX=0) -> WE=0 both slots, ERR=1, ERR_CNT=2. Pulse ERR_CLR -> ERR=0, ERR_CNT=0. Drive 300 illegal requests -> ERR_CNT=255.
- Full and streaming: hold REQ_VALID=1 with HOLD=0 for 10 requests -> 10 WE pulses on 10 consecutive cycles, with no drops or duplicates.
- Reset mid-operation: HOLD=1, 2 entries queued, assert RST 1 cycle, release HOLD -> no WE pulse; FIFO empty, REQ_READY=1.
